// File: rtl/bus_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_rr_if
//  Description : Request/grant bundle for the shared Canny datapath bus.
//                master : arbiter side (samples BREQn, drives grants)
//                slave  : requester side (drives BREQn, observes grants)
//  Signals     : BREQn    [NumUnit-1:0] active-low requests, one per unit
//                BGNTn    [NumUnit-1:0] active-low grants, at most one low
//                grant_id [IdW-1:0]     current owner, valid when bus_busy
//                bus_busy               1 while a grant is asserted
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_rr_if #(
   parameter int NumUnit = 3
);
   localparam int IdW = (NumUnit > 1) ? $clog2(NumUnit) : 1;

   logic [NumUnit-1:0] BREQn;
   logic [NumUnit-1:0] BGNTn;
   logic [IdW-1:0]     grant_id;
   logic               bus_busy;

   modport master (
      input  BREQn,
      output BGNTn,
      output grant_id,
      output bus_busy
   );

   modport slave (
      output BREQn,
      input  BGNTn,
      input  grant_id,
      input  bus_busy
   );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_rr
//  Description : Registered bus arbiter. One absolute-priority unit
//                (PrioUnit) may preempt any owner; all other units share the
//                bus round-robin. A non-priority owner is revoked after
//                MaxHold consecutive grant cycles when someone else waits
//                (MaxHold = 0 disables that limit). Every ownership change
//                passes through one idle cycle.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - bus_arbiter_rr_if.master (BREQn in; BGNTn, grant_id,
//                       bus_busy out, all straight from registers)
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
   parameter int NumUnit  = 3,
   parameter int PrioUnit = 2,
   parameter int MaxHold  = 16
) (
   input  wire                      clk,
   input  wire                      rst,
   bus_arbiter_rr_if.master         bus
);

   localparam int IdW   = (NumUnit > 1) ? $clog2(NumUnit) : 1;
   localparam int HoldW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;

   localparam logic [IdW-1:0]     c_prio_id   = IdW'(PrioUnit);
   localparam logic [IdW-1:0]     c_last_id   = IdW'(NumUnit - 1);
   localparam logic [NumUnit-1:0] c_one       = NumUnit'(1);
   localparam logic [NumUnit-1:0] c_prio_mask = c_one << PrioUnit;
   localparam logic [HoldW-1:0]   c_max_hold  = HoldW'(MaxHold);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_OWNED = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t             r_state;
   logic [NumUnit-1:0] r_bgntn;
   logic [IdW-1:0]     r_grant_id;
   logic [HoldW-1:0]   r_hold;
   // First unit examined by the next round-robin search (last RR winner + 1).
   logic [IdW-1:0]     r_rr_ptr;

   // ------------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------------
   state_t             w_state_nxt;
   logic [NumUnit-1:0] w_bgntn_nxt;
   logic [IdW-1:0]     w_grant_id_nxt;
   logic [HoldW-1:0]   w_hold_nxt;
   logic [IdW-1:0]     w_rr_ptr_nxt;

   logic [NumUnit-1:0] w_req;
   logic               w_prio_req;
   logic               w_owner_req;
   logic               w_owner_prio;
   logic               w_others_req;
   logic               w_release;
   logic               w_preempt;
   logic               w_starve;
   logic               w_drop;

   logic               w_rr_found;
   logic [IdW-1:0]     w_rr_winner;
   logic [IdW-1:0]     w_rr_winner_inc;
   int                 v_idx;

   assign w_req      = ~bus.BREQn;
   assign w_prio_req = |(w_req & c_prio_mask);

   // The registered grant vector doubles as the owner mask: its zero bit is
   // the owner, its one bits are everybody else.
   assign w_owner_req  = |(w_req & ~r_bgntn);
   assign w_others_req = |(w_req &  r_bgntn);
   assign w_owner_prio = (r_grant_id == c_prio_id);

   assign w_release = ~w_owner_req;
   assign w_preempt = ~w_owner_prio & w_prio_req;
   assign w_starve  = ~w_owner_prio & (MaxHold != 0) &
                      (r_hold == c_max_hold) & w_others_req;
   assign w_drop    = w_release | w_preempt | w_starve;

   // Round-robin search: walk upward from r_rr_ptr with wraparound and take
   // the first requesting unit that is not the priority unit.
   always_comb begin
      w_rr_found  = 1'b0;
      w_rr_winner = '0;
      v_idx       = 0;
      for (int i = 0; i < NumUnit; i++) begin
         v_idx = int'(r_rr_ptr) + i;
         if (v_idx >= NumUnit) begin
            v_idx = v_idx - NumUnit;
         end
         if (!w_rr_found && (v_idx != PrioUnit) && w_req[v_idx[IdW-1:0]]) begin
            w_rr_found  = 1'b1;
            w_rr_winner = v_idx[IdW-1:0];
         end
      end
   end

   assign w_rr_winner_inc = (w_rr_winner == c_last_id) ? '0
                                                      : w_rr_winner + IdW'(1);

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_bgntn_nxt    = r_bgntn;
      w_grant_id_nxt = r_grant_id;
      w_hold_nxt     = r_hold;
      w_rr_ptr_nxt   = r_rr_ptr;

      case (r_state)
         S_IDLE: begin
            if (|w_req) begin
               w_state_nxt = S_OWNED;
               w_hold_nxt  = HoldW'(1);
               if (w_prio_req) begin
                  // Priority wins outright and leaves the RR pointer alone.
                  w_bgntn_nxt    = ~c_prio_mask;
                  w_grant_id_nxt = c_prio_id;
               end else if (w_rr_found) begin
                  w_bgntn_nxt    = ~(c_one << w_rr_winner);
                  w_grant_id_nxt = w_rr_winner;
                  w_rr_ptr_nxt   = w_rr_winner_inc;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_hold_nxt  = r_hold;
               end
            end
         end

         S_OWNED: begin
            if (w_drop) begin
               // Always return to idle: grants are never handed directly
               // from one owner to the next.
               w_state_nxt = S_IDLE;
               w_bgntn_nxt = '1;
               w_hold_nxt  = '0;
            end else if (r_hold < c_max_hold) begin
               w_hold_nxt = r_hold + HoldW'(1);
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_bgntn_nxt = '1;
            w_hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_bgntn    <= '1;
         r_grant_id <= '0;
         r_hold     <= '0;
         r_rr_ptr   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_bgntn    <= w_bgntn_nxt;
         r_grant_id <= w_grant_id_nxt;
         r_hold     <= w_hold_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
      end
   end

   assign bus.BGNTn    = r_bgntn;
   assign bus.grant_id = r_grant_id;
   assign bus.bus_busy = (r_state == S_OWNED);

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter_rr
//  Description : Self-checking bench for bus_arbiter_rr (NumUnit=3,
//                PrioUnit=2, MaxHold=4, plus a MaxHold=0 instance sharing
//                the same request inputs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

   localparam int N  = 3;
   localparam int P  = 2;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] breqn = '1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bus_arbiter_rr_if #(.NumUnit(N)) bif ();
   bus_arbiter_rr_if #(.NumUnit(N)) bif_nh ();

   assign bif.BREQn    = breqn;
   assign bif_nh.BREQn = breqn;

   bus_arbiter_rr #(.NumUnit(N), .PrioUnit(P), .MaxHold(MH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   bus_arbiter_rr #(.NumUnit(N), .PrioUnit(P), .MaxHold(0)) u_dut_nh (
      .clk (clk),
      .rst (rst),
      .bus (bif_nh)
   );

   // ------------------------------------------------------------------------
   // Reference model: owner as an integer (-1 = none), hold count, and the
   // unit where the next round-robin search starts.
   // ------------------------------------------------------------------------
   int m_owner = -1;
   int m_hold  = 0;
   int m_start = 0;

   function automatic bit req_of(input logic [N-1:0] bq, input int u);
      logic [N-1:0] rq;
      rq = ~bq;
      return rq[u[1:0]];
   endfunction

   task automatic model_step(input logic r, input logic [N-1:0] bq);
      bit any_req;
      bit others;
      bit found;
      int u;
      any_req = (bq != '1);
      if (r) begin
         m_owner = -1;
         m_hold  = 0;
         m_start = 0;
      end else if (m_owner < 0) begin
         if (any_req) begin
            if (req_of(bq, P)) begin
               m_owner = P;
               m_hold  = 1;
            end else begin
               found = 0;
               for (int i = 0; i < N; i++) begin
                  u = (m_start + i) % N;
                  if (!found && u != P && req_of(bq, u)) begin
                     found   = 1;
                     m_owner = u;
                     m_hold  = 1;
                     m_start = (u + 1) % N;
                  end
               end
            end
         end
      end else begin
         others = 0;
         for (int i = 0; i < N; i++) begin
            if (i != m_owner && req_of(bq, i)) others = 1;
         end
         if (!req_of(bq, m_owner) ||
             (m_owner != P && req_of(bq, P)) ||
             (m_owner != P && MH != 0 && m_hold == MH && others)) begin
            m_owner = -1;
            m_hold  = 0;
         end else if (m_hold < MH) begin
            m_hold = m_hold + 1;
         end
      end
   endtask

   function automatic logic [N-1:0] model_bgntn();
      logic [N-1:0] one;
      one = 1;
      if (m_owner < 0) return '1;
      return ~(one << m_owner);
   endfunction

   // ------------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".bgntn"}, int'(bif.BGNTn), int'(model_bgntn()));
      check({tag, ".busy"}, int'(bif.bus_busy), (m_owner >= 0) ? 1 : 0);
      if (m_owner >= 0) check({tag, ".id"}, int'(bif.grant_id), m_owner);
   endtask

   // Apply current rst/breqn at the next rising edge, advance the model in
   // step, and leave time 1 unit after the edge for sampling.
   task automatic tick();
      model_step(rst, breqn);
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------------
   // Vector table
   // ------------------------------------------------------------------------
   typedef struct {
      logic         rst;
      logic [N-1:0] breqn;
      logic [N-1:0] bgntn;
      logic         busy;
      logic [1:0]   id;
   } vec_t;

   localparam int NV = 34;
   vec_t tbl [NV];

   task automatic fill_table();
      // reset and single request / release
      tbl[0]  = '{1'b1, 3'b111, 3'b111, 1'b0, 2'd0};
      tbl[1]  = '{1'b1, 3'b111, 3'b111, 1'b0, 2'd0};
      tbl[2]  = '{1'b0, 3'b110, 3'b110, 1'b1, 2'd0};
      tbl[3]  = '{1'b0, 3'b111, 3'b111, 1'b0, 2'd0};
      tbl[4]  = '{1'b0, 3'b111, 3'b111, 1'b0, 2'd0};
      // round-robin 0,1,0,1 with owners releasing after 2 cycles
      tbl[5]  = '{1'b1, 3'b111, 3'b111, 1'b0, 2'd0};
      tbl[6]  = '{1'b0, 3'b100, 3'b110, 1'b1, 2'd0};
      tbl[7]  = '{1'b0, 3'b100, 3'b110, 1'b1, 2'd0};
      tbl[8]  = '{1'b0, 3'b101, 3'b111, 1'b0, 2'd0};
      tbl[9]  = '{1'b0, 3'b100, 3'b101, 1'b1, 2'd1};
      tbl[10] = '{1'b0, 3'b100, 3'b101, 1'b1, 2'd1};
      tbl[11] = '{1'b0, 3'b110, 3'b111, 1'b0, 2'd0};
      tbl[12] = '{1'b0, 3'b100, 3'b110, 1'b1, 2'd0};
      tbl[13] = '{1'b0, 3'b100, 3'b110, 1'b1, 2'd0};
      tbl[14] = '{1'b0, 3'b101, 3'b111, 1'b0, 2'd0};
      tbl[15] = '{1'b0, 3'b100, 3'b101, 1'b1, 2'd1};
      // preemption of unit 1 by unit 2
      tbl[16] = '{1'b0, 3'b001, 3'b111, 1'b0, 2'd0};
      tbl[17] = '{1'b0, 3'b001, 3'b011, 1'b1, 2'd2};
      tbl[18] = '{1'b0, 3'b001, 3'b011, 1'b1, 2'd2};
      tbl[19] = '{1'b0, 3'b000, 3'b011, 1'b1, 2'd2};
      tbl[20] = '{1'b0, 3'b100, 3'b111, 1'b0, 2'd0};
      // starvation: unit 0 holds exactly 4 cycles while unit 1 waits
      tbl[21] = '{1'b0, 3'b100, 3'b110, 1'b1, 2'd0};
      tbl[22] = '{1'b0, 3'b100, 3'b110, 1'b1, 2'd0};
      tbl[23] = '{1'b0, 3'b100, 3'b110, 1'b1, 2'd0};
      tbl[24] = '{1'b0, 3'b100, 3'b110, 1'b1, 2'd0};
      tbl[25] = '{1'b0, 3'b100, 3'b111, 1'b0, 2'd0};
      tbl[26] = '{1'b0, 3'b100, 3'b101, 1'b1, 2'd1};
      // priority beats RR candidates in idle
      tbl[27] = '{1'b0, 3'b111, 3'b111, 1'b0, 2'd0};
      tbl[28] = '{1'b0, 3'b000, 3'b011, 1'b1, 2'd2};
      tbl[29] = '{1'b0, 3'b111, 3'b111, 1'b0, 2'd0};
      // simultaneous release and preemption -> single revoke
      tbl[30] = '{1'b0, 3'b110, 3'b110, 1'b1, 2'd0};
      tbl[31] = '{1'b0, 3'b011, 3'b111, 1'b0, 2'd0};
      tbl[32] = '{1'b0, 3'b011, 3'b011, 1'b1, 2'd2};
      tbl[33] = '{1'b0, 3'b111, 3'b111, 1'b0, 2'd0};
   endtask

   // ------------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------------
   initial begin
      fill_table();

      for (int v = 0; v < NV; v++) begin
         rst   = tbl[v].rst;
         breqn = tbl[v].breqn;
         tick();
         check($sformatf("vec%0d.bgntn", v), int'(bif.BGNTn), int'(tbl[v].bgntn));
         check($sformatf("vec%0d.busy", v), int'(bif.bus_busy), int'(tbl[v].busy));
         if (tbl[v].busy || tbl[v].rst)
            check($sformatf("vec%0d.id", v), int'(bif.grant_id), int'(tbl[v].id));
         check_model($sformatf("vec%0d.model", v));
      end

      // Mid-grant reset: unit 0 owns, reset pulse, then unit 0 wins first.
      rst = 1'b0; breqn = 3'b110; tick();
      check("mid.own_before", int'(bif.BGNTn), 3'b110);
      rst = 1'b1; tick();
      check("mid.rst_bgntn", int'(bif.BGNTn), 3'b111);
      check("mid.rst_busy", int'(bif.bus_busy), 0);
      check("mid.rst_id", int'(bif.grant_id), 0);
      rst = 1'b0; breqn = 3'b100; tick();
      check("mid.first_bgntn", int'(bif.BGNTn), 3'b110);
      check("mid.first_id", int'(bif.grant_id), 0);
      breqn = 3'b111; tick();

      // Priority unit keeps the bus for 20 cycles despite other requests.
      breqn = 3'b101; tick();
      check("prio.u1_owns", int'(bif.BGNTn), 3'b101);
      breqn = 3'b001; tick();
      check("prio.revoke", int'(bif.BGNTn), 3'b111);
      tick();
      check("prio.grant", int'(bif.BGNTn), 3'b011);
      check("prio.id", int'(bif.grant_id), 2);
      for (int c = 0; c < 20; c++) begin
         breqn = {1'b0, 2'($urandom)};
         tick();
         check($sformatf("prio.hold%0d", c), int'(bif.BGNTn), 3'b011);
         check_model("prio.model");
      end
      breqn = 3'b111; tick();
      check("prio.release", int'(bif.BGNTn), 3'b111);

      // MaxHold = 0: unit 0 holds indefinitely while unit 1 waits.
      rst = 1'b1; tick();
      rst = 1'b0; breqn = 3'b110; tick();
      check("nh.grant", int'(bif_nh.BGNTn), 3'b110);
      breqn = 3'b100;
      for (int c = 0; c < 12; c++) begin
         tick();
         check($sformatf("nh.hold%0d", c), int'(bif_nh.BGNTn), 3'b110);
         check_model("nh.main_model");
      end
      breqn = 3'b111; tick();
      check("nh.release", int'(bif_nh.BGNTn), 3'b111);

      // Random traffic against the model plus structural invariants.
      for (int c = 0; c < 10000; c++) begin
         rst   = ($urandom_range(0, 499) == 0);
         breqn = 3'($urandom);
         tick();
         check_model("rand");
         check("rand.onehot", ($countones(~bif.BGNTn) <= 1) ? 1 : 0, 1);
         check("rand.busy_eq", int'(bif.bus_busy), int'(~&bif.BGNTn));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
